// File: rtl/jtcontra_slot_cache.sv
// Two-line ROM read cache for one SDRAM arbiter slot. Misses become a single
// 16-bit SDRAM word request; 8-bit clients get both bytes out of one fetch.
module jtcontra_slot_cache #(
  parameter int          AW     = 18,
  parameter int          DW     = 8,
  parameter logic [21:0] OFFSET = 22'h0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          downloading,
  input  logic [AW-1:0] addr,
  input  logic          addr_ok,
  output logic [DW-1:0] dout,
  output logic          data_ok,
  output logic          sdram_req,
  output logic [21:0]   sdram_addr,
  input  logic          sdram_ack,
  input  logic          data_rdy,
  input  logic [15:0]   data_read
);

  localparam int TW = (DW == 8) ? AW - 1 : AW;

  typedef enum logic [1:0] { S_IDLE, S_REQ, S_WAIT } state_t;

  state_t               state;
  logic [TW-1:0]        tag, miss_tag;
  logic [AW-1:0]        addr_q;
  logic [1:0]           vld;
  logic [1:0][TW-1:0]   ltag;
  logic [1:0][15:0]     ldata;
  logic                 victim;
  logic                 hit0, hit1, hit;
  logic [15:0]          hword;
  logic [DW-1:0]        hsel;

  generate
    if (DW == 8) begin : g_byte
      assign tag  = addr[AW-1:1];
      assign hsel = addr[0] ? hword[15:8] : hword[7:0];
    end else begin : g_word
      assign tag  = addr;
      assign hsel = hword;
    end
  endgenerate

  // Line 0 takes priority if a refill race left both lines with the same tag
  assign hit0  = vld[0] && (ltag[0] == tag);
  assign hit1  = vld[1] && (ltag[1] == tag);
  assign hit   = addr_ok && (hit0 || hit1);
  assign hword = hit0 ? ldata[0] : ldata[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      miss_tag   <= '0;
      addr_q     <= '0;
      vld        <= '0;
      ltag       <= '0;
      ldata      <= '0;
      victim     <= 1'b0;
      dout       <= '0;
      data_ok    <= 1'b0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
    end else begin
      addr_q  <= addr;
      data_ok <= hit && (addr == addr_q);
      if (hit) dout <= hsel;
      if (downloading) begin
        vld       <= '0;
        state     <= S_IDLE;
        sdram_req <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (addr_ok && !hit) begin
            miss_tag   <= tag;
            sdram_addr <= OFFSET + 22'(tag);
            state      <= S_REQ;
          end
          S_REQ: if (sdram_ack) begin
            sdram_req <= 1'b0;
            state     <= S_WAIT;
          end else begin
            sdram_req <= 1'b1;
          end
          // A retracted client still gets its fill; IDLE re-evaluates the new addr
          S_WAIT: if (data_rdy) begin
            ltag[victim]  <= miss_tag;
            ldata[victim] <= data_read;
            vld[victim]   <= 1'b1;
            victim        <= ~victim;
            state         <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/jtcontra_slot_cache.md
# jtcontra_slot_cache

Per-slot ROM request and cache stage that sits between a game client (main CPU, sound CPU, ADPCM or tile/object fetcher) and one slot of the SDRAM ROM arbiter in the Contra-family game top. It holds two 16-bit SDRAM words, answers repeated client reads locally, and turns misses into a single-word SDRAM request at an offset address. A 16-bit word is fetched once and both of its bytes are then served to 8-bit clients.

## Interface
Parameters:
- AW, 18, client address width in client-word units.
- DW, 8, client data width; only 8 or 16 are legal.
- OFFSET, 22'h0, SDRAM word offset added to every slot address.

Ports:
- clk  in  1  system clock. All logic is on this one clock.
- rst_n  in  1  asynchronous, active-low reset.
- downloading  in  1  ROM download in progress. Invalidates the cache and aborts any miss.
- addr  in  AW  client read address.
- addr_ok  in  1  client chip-select; addr is valid.
- dout  out  DW  read data.
- data_ok  out  1  dout is valid for the current addr.
- sdram_req  out  1  request to the arbiter.
- sdram_addr  out  22  SDRAM word address of the request.
- sdram_ack  in  1  arbiter accepted the request (one-cycle pulse).
- data_rdy  in  1  data_read holds this slot's word (one-cycle pulse).
- data_read  in  16  SDRAM read data.

## Operation
- Word tag:
  - DW=8: tag = addr[AW-1:1]; byte select = addr[0]. addr[0]=0 selects data_read[7:0], 1 selects [15:8].
  - DW=16: tag = addr.
- Two lines, each holding {valid, tag, data[15:0]}. A 1-bit victim pointer selects the replacement line and toggles on every fill.
- Hit: addr_ok=1 and any valid line has a tag equal to the current tag. If both lines match, line 0 wins. This can only happen after a refill race.
- sdram_addr = OFFSET + zero-extended tag, truncated to 22 bits, so it wraps modulo 2^22. It is registered when the miss starts and is held stable until the fill completes.
- State machine:
  - IDLE: if addr_ok=1, there is no hit, and downloading=0, latch the miss tag and go to REQ.
  - REQ: sdram_req=1. On sdram_ack go to WAIT and drop sdram_req in the same edge.
  - WAIT: on data_rdy, write data_read, the latched tag and valid=1 into the victim line, toggle the victim pointer, and go to IDLE.
- Client retraction: if addr_ok falls or addr changes while in REQ or WAIT, the request is not withdrawn. The fill completes into the cache, and the new address is evaluated back in IDLE.
- data_ok:
  - Registered each cycle as addr_ok and hit and (addr == addr_q), where addr_q is the previous cycle's addr.
  - dout is registered with the hit line's selected byte or word.
  - A cycle in which addr differs from addr_q always produces data_ok=0 in the following cycle.
- downloading=1: all valid bits clear, the FSM goes to IDLE, and sdram_req drops at the next edge. No misses start while downloading stays high.
- Simultaneous events:
  - downloading together with data_rdy: downloading wins and no line is written.
  - sdram_ack in IDLE or WAIT, or data_rdy in IDLE or REQ, is ignored.

## Timing
- Reset values: dout=0, data_ok=0, sdram_req=0, sdram_addr=0, both lines invalid, victim=0, FSM=IDLE, addr_q=0.
- Hit latency: addr stable at edge N gives data_ok=1 with valid dout after edge N+1. A new address therefore costs at least one cycle of data_ok=0.
- Miss latency:
  - sdram_req rises at edge N+1 after the miss is detected at N.
  - After data_rdy at edge M, data_ok=1 after edge M+1 when addr is unchanged.
  - Total latency = 2 + arbiter ack wait + SDRAM read latency.
- sdram_req stays high until ack, never glitches, and is never re-asserted in the cycle of the ack.
- A reset assertion mid-miss clears everything asynchronously. A late data_rdy after reset release is ignored because the FSM is in IDLE.

## Test plan
- Reset: hold rst_n=0, drive addr_ok=1 -> sdram_req=0 and data_ok=0. Release -> sdram_req=1 two edges later with sdram_addr=OFFSET+tag.
- DW=8, OFFSET=22'h10000, read addr=18'h00005:
  - Expect sdram_addr=22'h10002.
  - Ack, then data_rdy with data_read=16'hBEEF -> dout=8'hBE, data_ok=1.
  - Switch to addr 18'h00004 -> no new sdram_req; dout=8'hEF after one data_ok=0 cycle.
- Three distinct tags A, B, C fetched in order -> C evicts A (victim round-robin). Re-reading B hits with no request; re-reading A issues a new request.
- Retraction: drop addr_ok during REQ -> sdram_req stays high until sdram_ack. data_rdy then fills the line; a later read of that tag hits with zero requests.
- Wrap: DW=16, OFFSET=22'h3FFFFF, addr=2 -> sdram_addr=22'h000001.
- Download: assert downloading during WAIT together with data_rdy -> no fill, sdram_req=0. After deassertion, the prior-hit address misses again.
